// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED bar sequencer.
// Optional feature macro: LED_SEQ_CHASE_EN (adds the CHASE mode and the 'c' command).
package led_seq_pkg;

  // Display modes reported on o_mode; CHASE exists only when the chase feature is built
  typedef enum logic [2:0] {
    MODE_FOLLOW = 3'd0,
    MODE_HOLD   = 3'd1,
    MODE_BLINK  = 3'd2
`ifdef LED_SEQ_CHASE_EN
    ,
    MODE_CHASE  = 3'd3
`endif
  } mode_e;

  // FIFO reader: IDLE issues the pop, WAIT lets the FIFO present the byte
  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_WAIT = 1'b1
  } rd_state_e;

  // Result of decoding one popped byte
  typedef struct packed {
    logic       hit;
    mode_e      mode;
    logic [3:0] digit;
  } cmd_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] CMD_BLINK  = 8'h62;
  localparam logic [7:0] CMD_CHASE  = 8'h63;
  localparam logic [7:0] CMD_NORMAL = 8'h6E;

  // Digit to bar pattern: 1..9 lights bit d-1, anything else is dark
  function automatic logic [8:0] dec(input logic [3:0] d);
    logic [8:0] r;
    if ((d >= 4'd1) && (d <= 4'd9)) begin
      r = 9'd1 << (d - 4'd1);
    end else begin
      r = 9'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/led_seq_tick.sv
// Free-running animation tick: counts 0..PERIOD-1 and pulses on the last count.
// i_clr restarts the count so the next pulse comes a full period later.
module led_seq_tick #(
  parameter int unsigned PERIOD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear on request, wrap at the end of the period
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/led_bar_sequencer.sv
// Mode scheduler for the 9-LED bar: shows the counter digit by default and
// reacts to ASCII commands popped from the UART RX FIFO (hold/blink/chase/follow).
// Optional feature macro: LED_SEQ_CHASE_EN (enables CHASE mode via 'c').
module led_bar_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned TICK_HZ    = 10,
  parameter int unsigned HOLD_TICKS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_2,
  input  logic       sw_3,
  input  logic [3:0] i_cnt_digit,
  input  logic       i_fifo_empty,
  input  logic [7:0] i_fifo_rdata,
  output logic       o_fifo_rd,
  output logic [2:0] o_mode,
  output logic [8:0] o_led_data
);

  localparam int unsigned TICK_P = CLK_HZ / TICK_HZ;
  localparam int unsigned HCW    = $clog2(HOLD_TICKS + 1);
  localparam logic [HCW-1:0] HOLD_END = HCW'(HOLD_TICKS);

  rd_state_e     rd_state_q, rd_state_d;
  logic          rd_q, rd_d;
  logic          cmd_vld_q, cmd_vld_d;
  mode_e         mode_q, mode_d;
  logic [3:0]    hold_digit_q, hold_digit_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic          blink_ph_q, blink_ph_d;
`ifdef LED_SEQ_CHASE_EN
  logic [8:0]    chase_q, chase_d;
`endif
  logic [8:0]    led_q, led_d;
  cmd_t          cmd_s;
  logic          tick_s;
  logic          tick_clr_s;

  led_seq_tick #(
    .PERIOD (TICK_P)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (tick_clr_s),
    .o_tick (tick_s)
  );

  // Reader next state: pop once when data is available, then wait for the byte.
  // The byte is valid the cycle after the strobe, which is the cycle after WAIT.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_d       = 1'b0;
    cmd_vld_d  = (rd_state_q == RD_WAIT);
    case (rd_state_q)
      RD_IDLE: begin
        if (!i_fifo_empty) begin
          rd_d       = 1'b1;
          rd_state_d = RD_WAIT;
        end else begin
          rd_state_d = RD_IDLE;
        end
      end
      RD_WAIT: begin
        rd_state_d = RD_IDLE;
      end
      default: begin
        rd_state_d = RD_IDLE;
      end
    endcase
  end

  // Command decode of the byte delivered by the FIFO
  always_comb begin
    cmd_s.hit   = 1'b0;
    cmd_s.mode  = MODE_FOLLOW;
    cmd_s.digit = 4'd0;
    if (cmd_vld_q) begin
      case (i_fifo_rdata)
        CMD_BLINK: begin
          cmd_s.hit  = 1'b1;
          cmd_s.mode = MODE_BLINK;
        end
`ifdef LED_SEQ_CHASE_EN
        CMD_CHASE: begin
          cmd_s.hit  = 1'b1;
          cmd_s.mode = MODE_CHASE;
        end
`endif
        CMD_NORMAL: begin
          cmd_s.hit  = 1'b1;
          cmd_s.mode = MODE_FOLLOW;
        end
        default: begin
          if ((i_fifo_rdata >= ASCII_ZERO) && (i_fifo_rdata <= ASCII_NINE)) begin
            cmd_s.hit   = 1'b1;
            cmd_s.mode  = MODE_HOLD;
            // 0x30..0x39: the low nibble is already byte - '0'
            cmd_s.digit = i_fifo_rdata[3:0];
          end else begin
            cmd_s.hit = 1'b0;
          end
        end
      endcase
    end else begin
      cmd_s.hit = 1'b0;
    end
  end

  // Mode scheduler: commands take priority over the tick; every entry restarts the tick
  always_comb begin
    mode_d       = mode_q;
    hold_digit_d = hold_digit_q;
    hold_cnt_d   = hold_cnt_q;
    blink_ph_d   = blink_ph_q;
`ifdef LED_SEQ_CHASE_EN
    chase_d      = chase_q;
`endif
    tick_clr_s   = 1'b0;
    if (cmd_s.hit) begin
      mode_d     = cmd_s.mode;
      tick_clr_s = 1'b1;
      case (cmd_s.mode)
        MODE_HOLD: begin
          hold_digit_d = cmd_s.digit;
          hold_cnt_d   = '0;
        end
        MODE_BLINK: begin
          blink_ph_d = 1'b1;
        end
`ifdef LED_SEQ_CHASE_EN
        MODE_CHASE: begin
          chase_d = 9'h001;
        end
`endif
        default: begin
          tick_clr_s = 1'b1;
        end
      endcase
    end else if (tick_s) begin
      case (mode_q)
        MODE_HOLD: begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
          if ((hold_cnt_q + HCW'(1)) == HOLD_END) begin
            mode_d     = MODE_FOLLOW;
            tick_clr_s = 1'b1;
          end else begin
            mode_d = MODE_HOLD;
          end
        end
        MODE_BLINK: begin
          blink_ph_d = ~blink_ph_q;
        end
`ifdef LED_SEQ_CHASE_EN
        MODE_CHASE: begin
          chase_d = {chase_q[7:0], chase_q[8]};
        end
`endif
        default: begin
          mode_d = mode_q;
        end
      endcase
    end else begin
      tick_clr_s = 1'b0;
    end
  end

  // Bar pattern from the next-cycle mode state so LEDs switch together with o_mode
  always_comb begin
    led_d = 9'd0;
    if (!(sw_2 && sw_3)) begin
      led_d = 9'd0;
    end else begin
      case (mode_d)
        MODE_FOLLOW: led_d = dec(i_cnt_digit);
        MODE_HOLD:   led_d = dec(hold_digit_d);
        MODE_BLINK: begin
          if (blink_ph_d) begin
            led_d = dec(i_cnt_digit);
          end else begin
            led_d = 9'd0;
          end
        end
`ifdef LED_SEQ_CHASE_EN
        MODE_CHASE:  led_d = chase_d;
`endif
        default:     led_d = 9'd0;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q   <= RD_IDLE;
      rd_q         <= 1'b0;
      cmd_vld_q    <= 1'b0;
      mode_q       <= MODE_FOLLOW;
      hold_digit_q <= 4'd0;
      hold_cnt_q   <= '0;
      blink_ph_q   <= 1'b0;
`ifdef LED_SEQ_CHASE_EN
      chase_q      <= 9'h001;
`endif
      led_q        <= 9'd0;
    end else begin
      rd_state_q   <= rd_state_d;
      rd_q         <= rd_d;
      cmd_vld_q    <= cmd_vld_d;
      mode_q       <= mode_d;
      hold_digit_q <= hold_digit_d;
      hold_cnt_q   <= hold_cnt_d;
      blink_ph_q   <= blink_ph_d;
`ifdef LED_SEQ_CHASE_EN
      chase_q      <= chase_d;
`endif
      led_q        <= led_d;
    end
  end

  assign o_fifo_rd  = rd_q;
  assign o_mode     = mode_q;
  assign o_led_data = led_q;

endmodule

// File: tb/tb_led_bar_sequencer.sv
// Directed bench for led_bar_sequencer with P=10 cycles per tick and HOLD_TICKS=3.
// Covers both builds: with and without LED_SEQ_CHASE_EN.
module tb_led_bar_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_2;
  logic       sw_3;
  logic [3:0] cnt_digit;
  logic       fifo_empty;
  logic [7:0] fifo_rdata = 8'h00;
  logic       fifo_rd;
  logic [2:0] mode;
  logic [8:0] led;

  int checks = 0;
  int errors = 0;

  // FIFO model
  logic [7:0] fifo_mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_cnt = 0;
  int pop_empty_cnt = 0;
  int cyc = 0;
  int last_pop_cyc = 0;
  int prev_pop_cyc = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  led_bar_sequencer #(
    .CLK_HZ     (20),
    .TICK_HZ    (2),
    .HOLD_TICKS (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_2         (sw_2),
    .sw_3         (sw_3),
    .i_cnt_digit  (cnt_digit),
    .i_fifo_empty (fifo_empty),
    .i_fifo_rdata (fifo_rdata),
    .o_fifo_rd    (fifo_rd),
    .o_mode       (mode),
    .o_led_data   (led)
  );

  // FIFO pop side: data appears the cycle after the strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd) begin
      if (wr_ptr == rd_ptr) begin
        pop_empty_cnt <= pop_empty_cnt + 1;
      end else begin
        fifo_rdata   <= fifo_mem[rd_ptr % 16];
        rd_ptr       <= rd_ptr + 1;
        pop_cnt      <= pop_cnt + 1;
        prev_pop_cyc <= last_pop_cyc;
        last_pop_cyc <= cyc;
      end
    end
  end

  typedef struct {
    logic       sw2;
    logic       sw3;
    logic [3:0] digit;
    logic [8:0] led;
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr % 16] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected animation pattern t cycles after entry (digit 3 for blink)
  function automatic logic [8:0] anim_exp(input int t);
    logic [8:0] one;
    one = 9'd1;
`ifdef LED_SEQ_CHASE_EN
    return one << ((t / 10) % 9);
`else
    return (((t / 10) % 2) == 0) ? 9'h004 : 9'h000;
`endif
  endfunction

  int ent;
  int pc0;
  logic [2:0] anim_mode;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 4'd0,  9'h000};
    vecs[1] = '{1'b1, 1'b1, 4'd1,  9'h001};
    vecs[2] = '{1'b1, 1'b1, 4'd5,  9'h010};
    vecs[3] = '{1'b1, 1'b1, 4'd12, 9'h000};
    vecs[4] = '{1'b1, 1'b1, 4'd9,  9'h100};
    vecs[5] = '{1'b1, 1'b1, 4'd10, 9'h000};
    vecs[6] = '{1'b1, 1'b0, 4'd7,  9'h000};
    vecs[7] = '{1'b0, 1'b1, 4'd7,  9'h000};
    vecs[8] = '{1'b1, 1'b1, 4'd8,  9'h080};
    vecs[9] = '{1'b1, 1'b1, 4'd15, 9'h000};
`ifdef LED_SEQ_CHASE_EN
    anim_mode = 3'd3;
`else
    anim_mode = 3'd2;
`endif

    rst = 1'b1; sw_2 = 1'b1; sw_3 = 1'b1; cnt_digit = 4'd5;
    repeat (3) step();
    check("reset_led", {23'd0, led}, 32'd0);
    check("reset_mode", {29'd0, mode}, 32'd0);
    check("reset_rd", {31'd0, fifo_rd}, 32'd0);
    rst = 1'b0;

    // FOLLOW table: one-cycle latency, out-of-range digits and disable
    for (int i = 0; i < 10; i++) begin
      sw_2 = vecs[i].sw2; sw_3 = vecs[i].sw3; cnt_digit = vecs[i].digit;
      step();
      check($sformatf("follow_led[%0d]", i), {23'd0, led}, {23'd0, vecs[i].led});
      check($sformatf("follow_mode[%0d]", i), {29'd0, mode}, 32'd0);
    end

    // HOLD '7' for 3 ticks, then back to FOLLOW
    sw_2 = 1'b1; sw_3 = 1'b1; cnt_digit = 4'd2;
    step();
    check("pre_hold_led", {23'd0, led}, 32'h002);
    push(8'h37);
    step();
    check("pop_strobe_on", {31'd0, fifo_rd}, 32'd1);
    step();
    check("pop_strobe_off", {31'd0, fifo_rd}, 32'd0);
    step();
    check("hold_mode", {29'd0, mode}, 32'd1);
    check("hold_led", {23'd0, led}, 32'h040);
    repeat (29) step();
    check("hold_still_mode", {29'd0, mode}, 32'd1);
    check("hold_still_led", {23'd0, led}, 32'h040);
    step();
    check("hold_expire_mode", {29'd0, mode}, 32'd0);
    check("hold_expire_led", {23'd0, led}, 32'h002);
    check("hold_pop_count", pop_cnt, 32'd1);

    // BLINK with digit 3: 10 cycles lit, 10 dark
    cnt_digit = 4'd3;
    push(8'h62);
    repeat (3) step();
    check("blink_mode", {29'd0, mode}, 32'd2);
    ent = cyc;
    for (int i = 0; i <= 20; i++) begin
      check($sformatf("blink_led[%0d]", i), {23'd0, led},
            {23'd0, ((((cyc - ent) / 10) % 2) == 0) ? 9'h004 : 9'h000});
      step();
    end

    // 'c': CHASE when built in, otherwise discarded
    push(8'h63);
    repeat (3) step();
    check("c_mode", {29'd0, mode}, {29'd0, anim_mode});
`ifdef LED_SEQ_CHASE_EN
    ent = cyc;
    for (int i = 0; i < 95; i++) begin
      check($sformatf("chase_led[%0d]", i), {23'd0, led}, {23'd0, anim_exp(cyc - ent)});
      step();
    end
`else
    check("c_led", {23'd0, led}, {23'd0, anim_exp(cyc - ent)});
`endif

    // Disable mid-animation: dark next cycle, animation keeps running
    sw_3 = 1'b0;
    step();
    check("dis_led", {23'd0, led}, 32'd0);
    check("dis_mode", {29'd0, mode}, {29'd0, anim_mode});
    repeat (14) step();
    sw_3 = 1'b1;
    step();
    check("resume_led", {23'd0, led}, {23'd0, anim_exp(cyc - ent)});

    // 'x' then 'n': two pops, unknown byte ignored, then FOLLOW
    pc0 = pop_cnt;
    push(8'h78);
    push(8'h6E);
    repeat (4) step();
    check("x_ignored_mode", {29'd0, mode}, {29'd0, anim_mode});
    step();
    check("n_mode", {29'd0, mode}, 32'd0);
    check("n_led", {23'd0, led}, 32'h004);
    check("xn_pops", pop_cnt - pc0, 32'd2);
    check("xn_gap", {31'd0, (last_pop_cyc - prev_pop_cyc) >= 2}, 32'd1);

    // Reset while the reader waits: byte is popped but never decoded
    pc0 = pop_cnt;
    push(8'h34);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (4) step();
    check("rstwait_mode", {29'd0, mode}, 32'd0);
    check("rstwait_led", {23'd0, led}, 32'h004);
    check("rstwait_pops", pop_cnt - pc0, 32'd1);
    check("rstwait_empty", {31'd0, fifo_empty}, 32'd1);

    check("no_pop_when_empty", pop_empty_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
